sequence_player: RTL and testbench

SEQUENCE_PLAYER -- requirements
Module: sequence_player

---
 rtl/sequence_player.sv | 147 ++++++++++++++
 tb/tb_sequence_player.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sequence_player.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sequence_player : plays stored color codes on an LED, paced by an external |
// |                   delay timer that is restarted for every on/off phase.    |
// | Revision 1.0                                                              |
// +----------------------------------------------------------------------------+

module sequence_player #(
   parameter int SEQ_DEPTH = 32,
   parameter int COLOR_W   = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               wr_en,
   input  logic [4:0]         wr_addr,
   input  logic [COLOR_W-1:0] wr_data,
   input  logic               start,
   input  logic [5:0]         play_len,
   input  logic [4:0]         speed,
   input  logic               abort,
   input  logic               delay_pulse,
   output logic               delay_rst,
   output logic [4:0]         delay_index,
   output logic               led_on,
   output logic [COLOR_W-1:0] led_color,
   output logic               busy,
   output logic               done
);

   localparam logic [5:0] c_max_len = 6'(SEQ_DEPTH);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ARM_ON  = 3'd1,
      LIGHT   = 3'd2,
      ARM_OFF = 3'd3,
      GAP     = 3'd4,
      DONE    = 3'd5
   } state_t;

   state_t             state_q;
   logic [COLOR_W-1:0] mem_q [SEQ_DEPTH];
   logic [4:0]         idx_q;
   logic [5:0]         len_q;
   logic [4:0]         spd_q;
   logic               led_on_q;
   logic [COLOR_W-1:0] led_color_q;
   logic               delay_rst_q;
   logic               busy_q;
   logic               done_q;
   logic               w_last;

   assign w_last = ({1'b0, idx_q} == (len_q - 6'd1));

   // Memory has no reset; a write is suppressed only while reset is high.
   always_ff @(posedge clk) begin
      if (wr_en && !reset) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         idx_q       <= 5'd0;
         len_q       <= 6'd0;
         spd_q       <= 5'd0;
         led_on_q    <= 1'b0;
         led_color_q <= '0;
         delay_rst_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         delay_rst_q <= 1'b0;
         done_q      <= 1'b0;
         if (abort && (state_q != IDLE)) begin
            state_q  <= IDLE;
            led_on_q <= 1'b0;
            busy_q   <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (start) begin
                     busy_q <= 1'b1;
                     if (play_len != 6'd0) begin
                        len_q       <= (play_len > c_max_len) ? c_max_len : play_len;
                        spd_q       <= speed;
                        idx_q       <= 5'd0;
                        delay_rst_q <= 1'b1;
                        state_q     <= ARM_ON;
                     end else begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                     end
                  end
               end
               ARM_ON: begin
                  led_color_q <= mem_q[idx_q];
                  led_on_q    <= 1'b1;
                  state_q     <= LIGHT;
               end
               LIGHT: begin
                  if (delay_pulse) begin
                     led_on_q    <= 1'b0;
                     delay_rst_q <= 1'b1;
                     state_q     <= ARM_OFF;
                  end
               end
               ARM_OFF: begin
                  state_q <= GAP;
               end
               GAP: begin
                  if (delay_pulse) begin
                     if (w_last) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                     end else begin
                        idx_q       <= idx_q + 5'd1;
                        delay_rst_q <= 1'b1;
                        state_q     <= ARM_ON;
                     end
                  end
               end
               DONE: begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
               default: begin
                  led_on_q <= 1'b0;
                  busy_q   <= 1'b0;
                  state_q  <= IDLE;
               end
            endcase
         end
      end
   end

   assign delay_rst   = delay_rst_q;
   assign delay_index = spd_q;
   assign led_on      = led_on_q;
   assign led_color   = led_color_q;
   assign busy        = busy_q;
   assign done        = done_q;

endmodule

`default_nettype wire

// File: tb/tb_sequence_player.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sequence_player : scoreboard bench for sequence_player.                 |
// | Revision 1.0                                                              |
// +----------------------------------------------------------------------------+

module tb_sequence_player;

   logic       clk;
   logic       reset;
   logic       wr_en;
   logic [4:0] wr_addr;
   logic [1:0] wr_data;
   logic       start;
   logic [5:0] play_len;
   logic [4:0] speed;
   logic       abort;
   logic       delay_pulse;
   logic       delay_rst;
   logic [4:0] delay_index;
   logic       led_on;
   logic [1:0] led_color;
   logic       busy;
   logic       done;

   sequence_player #(.SEQ_DEPTH(32), .COLOR_W(2)) dut (
      .clk         (clk),
      .reset       (reset),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .start       (start),
      .play_len    (play_len),
      .speed       (speed),
      .abort       (abort),
      .delay_pulse (delay_pulse),
      .delay_rst   (delay_rst),
      .delay_index (delay_index),
      .led_on      (led_on),
      .led_color   (led_color),
      .busy        (busy),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   logic [1:0] mem_model [32];
   logic [1:0] exp_colors [$];
   logic [1:0] obs_colors [$];
   int         obs_len [$];
   int         done_cnt, busy_cyc, on_cyc, done_cyc, idx_bad;
   bit         timed_out, post_busy, post_led, post_rst;
   logic [4:0] exp_spd = 5'd0;

   task automatic write_mem(input int addr, input logic [1:0] data);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 5'(addr); wr_data = data;
      mem_model[addr] = data;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   // Drives a start and pushes the colors the play is expected to show.
   task automatic begin_play(input int len, input logic [4:0] spd);
      int n;
      @(negedge clk);
      start = 1'b1; play_len = 6'(len); speed = spd;
      if (len > 0) exp_spd = spd;
      n = (len > 32) ? 32 : len;
      exp_colors.delete();
      for (int i = 0; i < n; i++) exp_colors.push_back(mem_model[i]);
   endtask

   // Runs the play with a model delay timer (pulse 11 cycles after delay_rst)
   // and records what the DUT shows. hook 1: abort in LIGHT of step hook_step;
   // hook 2: abort with the GAP pulse; hook 3: reset with the GAP pulse.
   task automatic watch(input int hook, input int hook_step, input bit hold_start);
      int cnt, steps, on_len;
      bit fired, prev_on;
      obs_colors.delete(); obs_len.delete();
      done_cnt = 0; busy_cyc = 0; on_cyc = 0; done_cyc = -1; idx_bad = 0;
      timed_out = 1; post_busy = 1; post_led = 1; post_rst = 1;
      cnt = 0; steps = 0; on_len = 0; fired = 0; prev_on = 0;
      for (int c = 1; c <= 4000; c++) begin
         @(negedge clk);
         if (!hold_start) start = 1'b0;
         abort = 1'b0; reset = 1'b0; delay_pulse = 1'b0;
         if (fired) begin
            post_busy = busy; post_led = led_on; post_rst = delay_rst;
            if (done) done_cnt++;
            timed_out = 0;
            break;
         end
         if (busy) busy_cyc++;
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = c;
         end
         if (busy && (delay_index != exp_spd)) idx_bad++;
         if (led_on) begin
            on_cyc++; on_len++;
            if (!prev_on) begin obs_colors.push_back(led_color); steps++; end
         end else if (prev_on) begin
            obs_len.push_back(on_len); on_len = 0;
         end
         prev_on = led_on;
         if (delay_rst) cnt = 11;
         else if (cnt > 0) begin cnt--; delay_pulse = (cnt == 0); end
         if (hook == 1 && led_on && steps == hook_step) begin abort = 1'b1; fired = 1; end
         if ((hook == 2 || hook == 3) && delay_pulse && !led_on && steps == hook_step) begin
            if (hook == 2) abort = 1'b1; else reset = 1'b1;
            fired = 1;
         end
         if (!busy && busy_cyc > 0 && !fired) begin timed_out = 0; break; end
      end
   endtask

   task automatic test_reset;
      @(negedge clk);
      reset = 1'b1; start = 1'b1; abort = 1'b1; wr_en = 1'b1; play_len = 6'd5;
      speed = 5'd9; delay_pulse = 1'b1;
      repeat (2) @(negedge clk);
      checks += 6;
      if (led_on !== 1'b0) begin errors++; $display("FAIL reset_led_on got %b want 0", led_on); end
      if (led_color !== 2'd0) begin errors++; $display("FAIL reset_led_color got %0d want 0", led_color); end
      if (delay_rst !== 1'b0) begin errors++; $display("FAIL reset_delay_rst got %b want 0", delay_rst); end
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
      if (delay_index !== 5'd0) begin errors++; $display("FAIL reset_delay_index got %0d want 0", delay_index); end
      reset = 1'b0; start = 1'b0; abort = 1'b0; wr_en = 1'b0; delay_pulse = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
   endtask

   task automatic test_basic;
      logic [1:0] e;
      write_mem(0, 2'd1); write_mem(1, 2'd3); write_mem(2, 2'd2);
      begin_play(3, 5'd7);
      watch(0, 0, 0);
      checks += 4;
      if (timed_out) begin errors++; $display("FAIL basic_timeout got 1 want 0"); end
      if (obs_colors.size() != 3) begin errors++; $display("FAIL basic_steps got %0d want 3", obs_colors.size()); end
      if (done_cnt != 1) begin errors++; $display("FAIL basic_done got %0d want 1", done_cnt); end
      if (idx_bad != 0) begin errors++; $display("FAIL basic_delay_index got %0d bad cycles want 0", idx_bad); end
      for (int i = 0; i < obs_colors.size() && exp_colors.size() > 0; i++) begin
         e = exp_colors.pop_front();
         checks++;
         if (obs_colors[i] !== e) begin errors++; $display("FAIL basic_color%0d got %0d want %0d", i, obs_colors[i], e); end
      end
      for (int i = 0; i < obs_len.size(); i++) begin
         checks++;
         if (obs_len[i] != 11) begin errors++; $display("FAIL basic_on_len%0d got %0d want 11", i, obs_len[i]); end
      end
      @(negedge clk);
      checks++;
      if (delay_index !== 5'd7) begin errors++; $display("FAIL idle_hold_index got %0d want 7", delay_index); end
   endtask

   task automatic test_zero_len;
      begin_play(0, 5'd5);
      watch(0, 0, 0);
      checks += 4;
      if (busy_cyc != 1) begin errors++; $display("FAIL zero_busy_cycles got %0d want 1", busy_cyc); end
      if (done_cyc != 1) begin errors++; $display("FAIL zero_done_cycle got %0d want 1", done_cyc); end
      if (on_cyc != 0) begin errors++; $display("FAIL zero_led_on got %0d want 0", on_cyc); end
      if (delay_index !== 5'd7) begin errors++; $display("FAIL zero_keep_speed got %0d want 7", delay_index); end
   endtask

   task automatic test_abort_light;
      logic [1:0] e;
      write_mem(0, 2'd2); write_mem(1, 2'd1); write_mem(2, 2'd3); write_mem(3, 2'd0);
      begin_play(4, 5'd3);
      watch(1, 2, 0);
      checks += 4;
      if (post_busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", post_busy); end
      if (post_led !== 1'b0) begin errors++; $display("FAIL abort_led_on got %b want 0", post_led); end
      if (done_cnt != 0) begin errors++; $display("FAIL abort_done got %0d want 0", done_cnt); end
      if (obs_colors.size() != 2) begin errors++; $display("FAIL abort_steps got %0d want 2", obs_colors.size()); end
      begin_play(4, 5'd3);
      watch(0, 0, 0);
      checks += 2;
      if (obs_colors.size() != 4) begin errors++; $display("FAIL replay_steps got %0d want 4", obs_colors.size()); end
      if (done_cnt != 1) begin errors++; $display("FAIL replay_done got %0d want 1", done_cnt); end
      for (int i = 0; i < obs_colors.size() && exp_colors.size() > 0; i++) begin
         e = exp_colors.pop_front();
         checks++;
         if (obs_colors[i] !== e) begin errors++; $display("FAIL replay_color%0d got %0d want %0d", i, obs_colors[i], e); end
      end
   endtask

   task automatic test_pulse_abort;
      begin_play(3, 5'd4);
      watch(2, 1, 0);
      checks += 4;
      if (post_busy !== 1'b0) begin errors++; $display("FAIL gap_abort_busy got %b want 0", post_busy); end
      if (post_rst !== 1'b0) begin errors++; $display("FAIL gap_abort_arm_on got %b want 0", post_rst); end
      if (done_cnt != 0) begin errors++; $display("FAIL gap_abort_done got %0d want 0", done_cnt); end
      if (obs_colors.size() != 1) begin errors++; $display("FAIL gap_abort_steps got %0d want 1", obs_colors.size()); end
   endtask

   task automatic test_len_cap;
      logic [1:0] e;
      for (int i = 0; i < 32; i++) write_mem(i, 2'($urandom_range(0, 3)));
      begin_play(40, 5'd1);
      watch(0, 0, 0);
      checks += 3;
      if (timed_out) begin errors++; $display("FAIL cap_timeout got 1 want 0"); end
      if (obs_colors.size() != 32) begin errors++; $display("FAIL cap_steps got %0d want 32", obs_colors.size()); end
      if (done_cnt != 1) begin errors++; $display("FAIL cap_done got %0d want 1", done_cnt); end
      for (int i = 0; i < obs_colors.size() && exp_colors.size() > 0; i++) begin
         e = exp_colors.pop_front();
         checks++;
         if (obs_colors[i] !== e) begin errors++; $display("FAIL cap_color%0d got %0d want %0d", i, obs_colors[i], e); end
      end
   endtask

   task automatic test_reset_mid;
      begin_play(10, 5'd9);
      watch(3, 5, 1);
      checks += 4;
      if (post_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", post_busy); end
      if (post_led !== 1'b0) begin errors++; $display("FAIL rst_mid_led_on got %b want 0", post_led); end
      if (done_cnt != 0) begin errors++; $display("FAIL rst_mid_done got %0d want 0", done_cnt); end
      if (obs_colors.size() != 5) begin errors++; $display("FAIL rst_mid_steps got %0d want 5", obs_colors.size()); end
      @(negedge clk);
      checks += 3;
      if (delay_rst !== 1'b1) begin errors++; $display("FAIL restart_arm_on got %b want 1", delay_rst); end
      if (busy !== 1'b1) begin errors++; $display("FAIL restart_busy got %b want 1", busy); end
      if (delay_index !== 5'd9) begin errors++; $display("FAIL restart_speed got %0d want 9", delay_index); end
      start = 1'b0; abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL restart_abort_busy got %b want 0", busy); end
   endtask

   initial begin
      reset = 1'b0; wr_en = 1'b0; wr_addr = 5'd0; wr_data = 2'd0; start = 1'b0;
      play_len = 6'd0; speed = 5'd0; abort = 1'b0; delay_pulse = 1'b0;
      for (int i = 0; i < 32; i++) mem_model[i] = 2'd0;
      test_reset();
      test_basic();
      test_zero_len();
      test_abort_light();
      test_pulse_abort();
      test_len_cap();
      test_reset_mid();
      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
